// File: rtl/johnson_bcd_pkg.sv
// Shared definitions for the 5-line digit code receiver: code table, error marker and FSM states.
package johnson_bcd_pkg;

   localparam logic [4:0] CODE_OF [0:9] = '{
      5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
      5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000
   };

   localparam logic [3:0] BCD_ERR = 4'hF;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

endpackage

// File: rtl/johnson_bcd_rx_johnson5_to_bcd.sv
// Combinational decoder from a 5-line digit code {d1..d5} to BCD, flagging codes outside the table.
module johnson5_to_bcd
   import johnson_bcd_pkg::*;
(
   input  logic [4:0] code,
   output logic [3:0] bcd,
   output logic       invalid
);

   always_comb begin
      bcd     = BCD_ERR;
      invalid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (code == CODE_OF[i]) begin
            bcd     = 4'(i);
            invalid = 1'b0;
         end
      end
   end

endmodule

// File: rtl/johnson_bcd_rx.sv
// Receives 5-line digit codes, assembles NDIGITS decoded digits (first digit in the MS nibble)
// into a BCD word and hands it downstream; invalid codes drop the partial word and are counted.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   COLLECT | accepting digit codes, filling slot idx of bcd_word
//   HOLD    | complete word presented on bcd_word, waiting for out_ready
module johnson_bcd_rx
   import johnson_bcd_pkg::*;
#(
   parameter int NDIGITS = 4,
   parameter int ERRW    = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4:0]             code,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NDIGITS-1:0]   bcd_word,
   output logic                   err_pulse,
   output logic                   err_sticky,
   output logic [ERRW-1:0]        err_count
);

   localparam int              IDXW     = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIGITS - 1);

   state_t          state;
   state_t          state_nxt;
   logic [IDXW-1:0] idx;
   logic [3:0]      dec_bcd;
   logic            dec_invalid;
   logic            in_xfer;
   logic            out_xfer;
   logic            in_ready_nxt;
   logic            out_valid_nxt;

   johnson5_to_bcd u_dec (
      .code    (code),
      .bcd     (dec_bcd),
      .invalid (dec_invalid)
   );

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= COLLECT;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         in_ready  <= in_ready_nxt;
         out_valid <= out_valid_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (in_xfer && !dec_invalid && idx == LAST_IDX) state_nxt = HOLD;
         HOLD:    if (out_xfer) state_nxt = COLLECT;
         default: state_nxt = COLLECT;
      endcase
   end

   // Handshake flags are registered from the next state so they stay glitch-free.
   always_comb begin
      in_ready_nxt  = (state_nxt == COLLECT);
      out_valid_nxt = (state_nxt == HOLD);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         idx        <= '0;
         bcd_word   <= '0;
         err_pulse  <= 1'b0;
         err_sticky <= 1'b0;
         err_count  <= '0;
      end else begin
         err_pulse <= in_xfer & dec_invalid;
         if (in_xfer) begin
            if (dec_invalid) begin
               idx        <= '0;
               err_sticky <= 1'b1;
               if (err_count != '1) err_count <= err_count + ERRW'(1);
            end else begin
               for (int i = 0; i < NDIGITS; i++) begin
                  if (idx == IDXW'(i)) bcd_word[(NDIGITS-1-i)*4 +: 4] <= dec_bcd;
               end
               idx <= (idx == LAST_IDX) ? '0 : idx + IDXW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_johnson_bcd_rx.sv
// Randomised scoreboard bench for johnson_bcd_rx: a digit-list reference model predicts words and
// error events, and a negedge monitor compares them whenever the DUT presents an output.
module tb_johnson_bcd_rx;

   localparam int NDIG = 4;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [4:0]  code;
   logic        out_ready;

   logic        in_ready,  out_valid,  err_pulse,  err_sticky;
   logic [15:0] bcd_word;
   logic [7:0]  err_count;

   logic        in_ready2, out_valid2, err_pulse2, err_sticky2;
   logic [15:0] bcd_word2;
   logic [1:0]  err_count2;

   logic [4:0]  sw_code;
   logic [3:0]  sw_bcd;
   logic        sw_inv;

   int n_checks = 0;
   int n_errors = 0;

   logic [4:0] tbl [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                            5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};

   int          part[$];
   logic [15:0] exp_words[$];
   int          err_q[$];
   logic        exp_hold   = 1'b0;
   logic        mdl_sticky = 1'b0;
   int          mdl_raw    = 0;
   logic        rst_prev   = 1'b0;

   johnson_bcd_rx #(.NDIGITS(NDIG), .ERRW(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .code(code),
      .out_valid(out_valid), .out_ready(out_ready), .bcd_word(bcd_word),
      .err_pulse(err_pulse), .err_sticky(err_sticky), .err_count(err_count)
   );

   johnson_bcd_rx #(.NDIGITS(NDIG), .ERRW(2)) dut2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .code(code),
      .out_valid(out_valid2), .out_ready(out_ready), .bcd_word(bcd_word2),
      .err_pulse(err_pulse2), .err_sticky(err_sticky2), .err_count(err_count2)
   );

   johnson5_to_bcd u_dec (.code(sw_code), .bcd(sw_bcd), .invalid(sw_inv));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic ref_decode(input logic [4:0] c, output int d, output bit ok);
      d  = 15;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) if (tbl[i] == c) begin d = i; ok = 1'b1; end
   endtask

   function automatic int sat(input int raw, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (raw > mx) ? mx : raw;
   endfunction

   task automatic model_clear();
      part.delete();
      exp_words.delete();
      err_q.delete();
      exp_hold   = 1'b0;
      mdl_sticky = 1'b0;
      mdl_raw    = 0;
   endtask

   task automatic model_accept(input logic [4:0] c);
      int          d;
      bit          ok;
      logic [15:0] w;
      ref_decode(c, d, ok);
      if (ok) begin
         part.push_back(d);
         if (part.size() == NDIG) begin
            w = 16'h0;
            foreach (part[i]) w = 16'(w * 16 + part[i]);
            exp_words.push_back(w);
            part.delete();
            exp_hold = 1'b1;
         end
      end else begin
         part.delete();
         mdl_sticky = 1'b1;
         mdl_raw++;
         err_q.push_back(mdl_raw);
      end
   endtask

   // One clock of stimulus; the model observes the handshake the DUT will see at the next edge.
   task automatic drive(input logic r, input logic v, input logic [4:0] c, input logic ordy);
      @(posedge clk);
      #1;
      reset     = r;
      in_valid  = v;
      code      = c;
      out_ready = ordy;
      @(negedge clk);
      #1;
      if (!reset) model_clear();
      else if (in_valid && in_ready) model_accept(code);
   endtask

   always @(negedge clk) begin
      if (!rst_prev) begin
         chk("rst_in_ready",   in_ready,   0);
         chk("rst_out_valid",  out_valid,  0);
         chk("rst_bcd_word",   bcd_word,   0);
         chk("rst_err_pulse",  err_pulse,  0);
         chk("rst_err_sticky", err_sticky, 0);
         chk("rst_err_count",  err_count,  0);
         chk("rst_err_count2", err_count2, 0);
      end else begin
         chk("in_ready",  in_ready,  !exp_hold);
         chk("out_valid", out_valid, exp_hold);
         if (exp_hold) begin
            if (exp_words.size() == 0) begin
               chk("word_queue_nonempty", 0, 1);
            end else begin
               chk("bcd_word", bcd_word, exp_words[0]);
               if (out_ready) begin
                  void'(exp_words.pop_front());
                  exp_hold = 1'b0;
               end
            end
         end
         chk("err_pulse", err_pulse, err_q.size() != 0);
         if (err_q.size() != 0) chk("err_count_at_pulse", err_count, sat(err_q.pop_front(), 8));
         chk("err_sticky", err_sticky, mdl_sticky);
         chk("err_count",  err_count,  sat(mdl_raw, 8));
         chk("err_count2", err_count2, sat(mdl_raw, 2));
      end
      rst_prev = reset;
   end

   initial begin
      int  d;
      bit  ok;
      logic [4:0] c;
      reset = 1'b0; in_valid = 1'b0; code = '0; out_ready = 1'b0; sw_code = '0;

      for (int i = 0; i < 32; i++) begin
         sw_code = 5'(i);
         #1;
         ref_decode(sw_code, d, ok);
         chk("dec_invalid", sw_inv, !ok);
         chk("dec_bcd", sw_bcd, ok ? d : 15);
      end

      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      drive(1, 0, 0, 1);

      drive(1, 1, 5'b10000, 1); drive(1, 1, 5'b00111, 1);
      drive(1, 1, 5'b11110, 1); drive(1, 1, 5'b00001, 1);
      repeat (3) drive(1, 0, 0, 1);

      drive(1, 1, 5'b10000, 0); drive(1, 1, 5'b00111, 0);
      drive(1, 1, 5'b11110, 0); drive(1, 1, 5'b00001, 0);
      repeat (5) drive(1, 1, 5'b00011, 0);
      drive(1, 0, 0, 1);
      drive(1, 0, 0, 1);

      drive(0, 0, 0, 0);
      drive(1, 1, 5'b00011, 1); drive(1, 1, 5'b01010, 1);
      drive(1, 1, 5'b11111, 1); drive(1, 1, 5'b11000, 1);
      drive(1, 1, 5'b00000, 1); drive(1, 1, 5'b01111, 1);
      repeat (2) drive(1, 0, 0, 1);

      drive(0, 0, 0, 0);
      drive(1, 1, 5'b01010, 1); drive(1, 1, 5'b10101, 1); drive(1, 1, 5'b00010, 1);
      drive(1, 1, 5'b11011, 1); drive(1, 1, 5'b01100, 1);
      repeat (2) drive(1, 0, 0, 1);

      drive(1, 1, 5'b00111, 1); drive(1, 1, 5'b11100, 1);
      drive(0, 0, 0, 1);
      drive(1, 1, 5'b00001, 1); drive(1, 1, 5'b00011, 1);
      drive(1, 1, 5'b11110, 1); drive(1, 1, 5'b10000, 1);
      repeat (2) drive(1, 0, 0, 1);

      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 4) != 0) c = tbl[$urandom_range(0, 9)];
         else c = 5'($urandom_range(0, 31));
         drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), c,
               ($urandom_range(0, 2) != 0));
      end

      repeat (4) drive(1, 0, 0, 1);
      chk("words_drained", exp_words.size(), 0);
      chk("errs_drained",  err_q.size(),     0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
